frame_sequencer: RTL and testbench

FRAME_SEQUENCER -- requirements
Module: frame_sequencer

---
 rtl/frame_sequencer.sv | 158 +++++++++++++++
 tb/tb_frame_sequencer.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/frame_sequencer.sv
// rtl/frame_sequencer.sv - Raster frame sequencer: tags an upstream pixel stream with coordinates
// and inserts idle blanking between rows.
module frame_sequencer #(
  parameter int unsigned IMAGE_WIDTH  = 128,
  parameter int unsigned IMAGE_HEIGHT = 128,
  parameter int unsigned HBLANK       = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        abort,
  input  logic        s_valid,
  input  logic [7:0]  s_data,
  output logic        s_ready,
  output logic [7:0]  pix_out,
  output logic        pix_valid,
  output logic [15:0] x_pos,
  output logic [15:0] y_pos,
  output logic        sof,
  output logic        eol,
  output logic        busy,
  output logic        done,
  output logic [15:0] frame_count
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_STREAM = 2'd1;
  localparam logic [1:0] S_BLANK  = 2'd2;
  localparam logic [1:0] S_DONE   = 2'd3;

  localparam logic [15:0] COL_LAST   = 16'(IMAGE_WIDTH - 1);
  localparam logic [15:0] ROW_LAST   = 16'(IMAGE_HEIGHT - 1);
  // Only meaningful when HBLANK > 0; BLANK is unreachable otherwise.
  localparam logic [7:0]  BLANK_LAST = (HBLANK > 0) ? 8'(HBLANK - 1) : 8'd0;

  logic [1:0]  state_q, state_d;
  logic [15:0] col_q, col_d;
  logic [15:0] row_q, row_d;
  logic [7:0]  blank_q, blank_d;
  logic [7:0]  pix_q, pix_d;
  logic        pv_q, pv_d;
  logic [15:0] x_q, x_d;
  logic [15:0] y_q, y_d;
  logic        sof_q, sof_d;
  logic        eol_q, eol_d;
  logic [15:0] fc_q, fc_d;
  logic        xfer;

  assign s_ready     = (state_q == S_STREAM) && !abort;
  assign xfer        = s_ready && s_valid;
  assign busy        = (state_q == S_STREAM) || (state_q == S_BLANK);
  assign done        = (state_q == S_DONE);
  assign pix_out     = pix_q;
  assign pix_valid   = pv_q;
  assign x_pos       = x_q;
  assign y_pos       = y_q;
  assign sof         = sof_q;
  assign eol         = eol_q;
  assign frame_count = fc_q;

  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    row_d   = row_q;
    blank_d = blank_q;
    pix_d   = pix_q;
    x_d     = x_q;
    y_d     = y_q;
    fc_d    = fc_q;
    pv_d    = 1'b0;
    sof_d   = 1'b0;
    eol_d   = 1'b0;

    // Output registers capture the pixel and the coordinates it was accepted at.
    if (xfer) begin
      pix_d = s_data;
      x_d   = col_q;
      y_d   = row_q;
      pv_d  = 1'b1;
      sof_d = (col_q == 16'd0) && (row_q == 16'd0);
      eol_d = (col_q == COL_LAST);
    end

    case (state_q)
      S_IDLE: begin
        if (start && !abort) begin
          state_d = S_STREAM;
          col_d   = 16'd0;
          row_d   = 16'd0;
          blank_d = 8'd0;
        end
      end
      S_STREAM: begin
        if (abort) begin
          state_d = S_IDLE;
        end else if (xfer) begin
          if (col_q == COL_LAST) begin
            col_d = 16'd0;
            if (row_q == ROW_LAST) begin
              state_d = S_DONE;
            end else begin
              row_d = row_q + 16'd1;
              if (HBLANK > 0) begin
                state_d = S_BLANK;
                blank_d = 8'd0;
              end
            end
          end else begin
            col_d = col_q + 16'd1;
          end
        end
      end
      S_BLANK: begin
        if (abort) begin
          state_d = S_IDLE;
        end else if (blank_q == BLANK_LAST) begin
          state_d = S_STREAM;
        end else begin
          blank_d = blank_q + 8'd1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        fc_d    = fc_q + 16'd1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      col_q   <= 16'd0;
      row_q   <= 16'd0;
      blank_q <= 8'd0;
      pix_q   <= 8'd0;
      pv_q    <= 1'b0;
      x_q     <= 16'd0;
      y_q     <= 16'd0;
      sof_q   <= 1'b0;
      eol_q   <= 1'b0;
      fc_q    <= 16'd0;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      row_q   <= row_d;
      blank_q <= blank_d;
      pix_q   <= pix_d;
      pv_q    <= pv_d;
      x_q     <= x_d;
      y_q     <= y_d;
      sof_q   <= sof_d;
      eol_q   <= eol_d;
      fc_q    <= fc_d;
    end
  end

endmodule

// File: tb/tb_frame_sequencer.sv
// tb/tb_frame_sequencer.sv - Directed bench for frame_sequencer; two instances (HBLANK=2 and 0)
// checked every cycle against a transfer-count reference model.
module tb_frame_sequencer;

  localparam int W    = 4;
  localparam int H    = 3;
  localparam int NPIX = W * H;
  localparam int HB0  = 2;
  localparam int HB1  = 0;

  logic clk = 1'b0;
  logic reset, start, abort, s_valid;
  logic [7:0] s_data;

  logic        s_ready     [2];
  logic [7:0]  pix_out     [2];
  logic        pix_valid   [2];
  logic [15:0] x_pos       [2];
  logic [15:0] y_pos       [2];
  logic        sof         [2];
  logic        eol         [2];
  logic        busy        [2];
  logic        done        [2];
  logic [15:0] frame_count [2];

  frame_sequencer #(.IMAGE_WIDTH(W), .IMAGE_HEIGHT(H), .HBLANK(HB0)) u0 (
    .clk(clk), .reset(reset), .start(start), .abort(abort),
    .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready[0]),
    .pix_out(pix_out[0]), .pix_valid(pix_valid[0]), .x_pos(x_pos[0]), .y_pos(y_pos[0]),
    .sof(sof[0]), .eol(eol[0]), .busy(busy[0]), .done(done[0]), .frame_count(frame_count[0])
  );

  frame_sequencer #(.IMAGE_WIDTH(W), .IMAGE_HEIGHT(H), .HBLANK(HB1)) u1 (
    .clk(clk), .reset(reset), .start(start), .abort(abort),
    .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready[1]),
    .pix_out(pix_out[1]), .pix_valid(pix_valid[1]), .x_pos(x_pos[1]), .y_pos(y_pos[1]),
    .sof(sof[1]), .eol(eol[1]), .busy(busy[1]), .done(done[1]), .frame_count(frame_count[1])
  );

  always #5 clk = ~clk;

  // Model: a frame is "n pixels accepted so far" plus a blanking countdown.
  bit          m_act  [2];
  bit          m_done [2];
  int          m_n    [2];
  int          m_gap  [2];
  bit          m_pv   [2];
  bit          m_sof  [2];
  bit          m_eol  [2];
  logic [7:0]  m_pix  [2];
  logic [15:0] m_x    [2];
  logic [15:0] m_y    [2];
  logic [15:0] m_fc   [2];

  int n_chk, n_fail;
  int k0;
  int pv_cnt [2], gap_cnt [2], done_cnt [2], sof_cnt [2];
  logic [7:0] sof_pix [2], eol_pix [2];

  function automatic int hb(input int i);
    return (i == 0) ? HB0 : HB1;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic timeout(input string nm);
    n_chk++;
    n_fail++;
    $display("FAIL %s: wait expired, expected event", nm);
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_act[i] = 0; m_done[i] = 0; m_n[i] = 0; m_gap[i] = 0;
      m_pv[i] = 0; m_sof[i] = 0; m_eol[i] = 0;
      m_pix[i] = '0; m_x[i] = '0; m_y[i] = '0; m_fc[i] = '0;
    end
  endtask

  task automatic model_step();
    for (int i = 0; i < 2; i++) begin
      bit rdy, xfer, was_done;
      rdy      = m_act[i] && (m_gap[i] == 0) && !abort;
      xfer     = rdy && s_valid;
      was_done = m_done[i];
      m_pv[i]  = xfer;
      m_sof[i] = xfer && (m_n[i] == 0);
      m_eol[i] = xfer && ((m_n[i] % W) == W - 1);
      if (xfer) begin
        m_pix[i] = s_data;
        m_x[i]   = 16'(m_n[i] % W);
        m_y[i]   = 16'(m_n[i] / W);
      end
      if (was_done) begin
        m_done[i] = 0;
        m_fc[i]   = m_fc[i] + 16'd1;
      end
      if (m_act[i]) begin
        if (abort) m_act[i] = 0;
        else if (m_gap[i] > 0) m_gap[i]--;
        else if (xfer) begin
          m_n[i]++;
          if (m_n[i] == NPIX) begin
            m_act[i]  = 0;
            m_done[i] = 1;
          end else if (m_n[i] % W == 0) begin
            m_gap[i] = hb(i);
          end
        end
      end else if (!was_done && start && !abort) begin
        m_act[i] = 1;
        m_n[i]   = 0;
        m_gap[i] = 0;
      end
    end
  endtask

  task automatic compare_all();
    for (int i = 0; i < 2; i++) begin
      logic exp_rdy;
      exp_rdy = m_act[i] && (m_gap[i] == 0) && !abort;
      chk($sformatf("u%0d.s_ready", i),     32'(s_ready[i]),     32'(exp_rdy));
      chk($sformatf("u%0d.pix_valid", i),   32'(pix_valid[i]),   32'(m_pv[i]));
      chk($sformatf("u%0d.pix_out", i),     32'(pix_out[i]),     32'(m_pix[i]));
      chk($sformatf("u%0d.x_pos", i),       32'(x_pos[i]),       32'(m_x[i]));
      chk($sformatf("u%0d.y_pos", i),       32'(y_pos[i]),       32'(m_y[i]));
      chk($sformatf("u%0d.sof", i),         32'(sof[i]),         32'(m_sof[i]));
      chk($sformatf("u%0d.eol", i),         32'(eol[i]),         32'(m_eol[i]));
      chk($sformatf("u%0d.busy", i),        32'(busy[i]),        32'(m_act[i]));
      chk($sformatf("u%0d.done", i),        32'(done[i]),        32'(m_done[i]));
      chk($sformatf("u%0d.frame_count", i), 32'(frame_count[i]), 32'(m_fc[i]));
      if (pix_valid[i]) pv_cnt[i]++;
      if (busy[i] && !s_ready[i] && !abort) gap_cnt[i]++;
      if (done[i]) done_cnt[i]++;
      if (sof[i]) begin sof_cnt[i]++; sof_pix[i] = pix_out[i]; end
      if (eol[i]) eol_pix[i] = pix_out[i];
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
    if (pix_valid[0]) k0++;
    s_data = 8'h10 + 8'(k0);
  endtask

  task automatic pulse_start();
    k0 = 0;
    s_data = 8'h10;
    start = 1'b1;
    cyc();
    start = 1'b0;
  endtask

  task automatic run_frame(input bit toggle);
    int n;
    n = 0;
    do begin
      s_valid = toggle ? ~s_valid : 1'b1;
      cyc();
      n++;
    end while ((busy[0] || busy[1] || done[0] || done[1]) && n < 200);
    if (n >= 200) timeout("frame_end");
    s_valid = 1'b0;
  endtask

  initial begin
    int pv0, pv1, gp0, gp1, dn0, sc0, n;
    reset = 1'b1; start = 1'b0; abort = 1'b0; s_valid = 1'b0; s_data = 8'h00;
    n_chk = 0; n_fail = 0; k0 = 0;
    for (int i = 0; i < 2; i++) begin
      pv_cnt[i] = 0; gap_cnt[i] = 0; done_cnt[i] = 0; sof_cnt[i] = 0;
      sof_pix[i] = '0; eol_pix[i] = '0;
    end
    model_reset();
    fork
      forever begin
        @(posedge clk or posedge reset);
        if (reset) model_reset(); else model_step();
      end
      forever begin
        @(negedge clk);
        compare_all();
      end
    join_none

    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    chk("reset_busy", 32'(busy[0]), 0);
    chk("reset_s_ready", 32'(s_ready[0]), 0);

    // Full frame, upstream always valid
    pv0 = pv_cnt[0]; pv1 = pv_cnt[1]; gp0 = gap_cnt[0]; gp1 = gap_cnt[1]; dn0 = done_cnt[0];
    pulse_start();
    run_frame(1'b0);
    chk("t1_pixels_u0", 32'(pv_cnt[0] - pv0), 12);
    chk("t1_pixels_u1", 32'(pv_cnt[1] - pv1), 12);
    chk("t1_blank_u0", 32'(gap_cnt[0] - gp0), 4);
    chk("t1_blank_u1", 32'(gap_cnt[1] - gp1), 0);
    chk("t1_done_u0", 32'(done_cnt[0] - dn0), 1);
    chk("t1_sof_pix", 32'(sof_pix[0]), 32'h10);
    chk("t1_last_pix", 32'(eol_pix[0]), 32'h1B);
    chk("t1_frame_count", 32'(frame_count[0]), 1);

    // Same frame with upstream toggling valid
    pv0 = pv_cnt[0]; gp0 = gap_cnt[0]; sc0 = sof_cnt[0];
    pulse_start();
    run_frame(1'b1);
    chk("t2_pixels_u0", 32'(pv_cnt[0] - pv0), 12);
    chk("t2_blank_u0", 32'(gap_cnt[0] - gp0), 4);
    chk("t2_sof_count", 32'(sof_cnt[0] - sc0), 1);
    chk("t2_last_pix", 32'(eol_pix[0]), 32'h1B);
    chk("t2_last_x", 32'(x_pos[0]), 3);
    chk("t2_last_y", 32'(y_pos[0]), 2);
    chk("t2_frame_count", 32'(frame_count[0]), 2);

    // Abort after the fifth accepted pixel, then a clean frame
    dn0 = done_cnt[0];
    pulse_start();
    s_valid = 1'b1;
    n = 0;
    while (k0 < 5 && n < 50) begin cyc(); n++; end
    if (n >= 50) timeout("t3_fifth_pixel");
    abort = 1'b1;
    #1 chk("t3_ready_in_abort", 32'(s_ready[0]), 0);
    cyc();
    abort = 1'b0;
    chk("t3_idle_u0", 32'(busy[0]), 0);
    chk("t3_idle_u1", 32'(busy[1]), 0);
    chk("t3_no_pixel", 32'(pix_valid[0]), 0);
    repeat (3) cyc();
    chk("t3_no_done", 32'(done_cnt[0] - dn0), 0);
    chk("t3_frame_count", 32'(frame_count[0]), 2);
    sc0 = sof_cnt[0];
    pulse_start();
    run_frame(1'b0);
    chk("t3_restart_sof", 32'(sof_cnt[0] - sc0), 1);
    chk("t3_restart_sof_pix", 32'(sof_pix[0]), 32'h10);
    chk("t3_frame_count_after", 32'(frame_count[0]), 3);

    // start mid-frame ignored; start with abort in IDLE ignored
    dn0 = done_cnt[0];
    pulse_start();
    s_valid = 1'b1;
    repeat (3) cyc();
    start = 1'b1;
    cyc();
    start = 1'b0;
    chk("t4_busy_kept", 32'(busy[0]), 1);
    run_frame(1'b0);
    chk("t4_one_done", 32'(done_cnt[0] - dn0), 1);
    chk("t4_frame_count", 32'(frame_count[0]), 4);
    start = 1'b1; abort = 1'b1;
    cyc();
    start = 1'b0; abort = 1'b0;
    chk("t4_abort_wins_u0", 32'(busy[0]), 0);
    chk("t4_abort_wins_u1", 32'(busy[1]), 0);
    repeat (2) cyc();
    chk("t4_frame_count_hold", 32'(frame_count[0]), 4);

    // Asynchronous reset in the middle of a blanking interval
    pulse_start();
    s_valid = 1'b1;
    n = 0;
    while (!(busy[0] && !s_ready[0]) && n < 50) begin cyc(); n++; end
    if (n >= 50) timeout("t5_blank");
    #2 reset = 1'b1;
    #1;
    chk("t5_pix_out", 32'(pix_out[0]), 0);
    chk("t5_pix_valid", 32'(pix_valid[0]), 0);
    chk("t5_x_pos", 32'(x_pos[0]), 0);
    chk("t5_y_pos", 32'(y_pos[0]), 0);
    chk("t5_sof", 32'(sof[0]), 0);
    chk("t5_eol", 32'(eol[0]), 0);
    chk("t5_busy", 32'(busy[0]), 0);
    chk("t5_done", 32'(done[0]), 0);
    chk("t5_frame_count", 32'(frame_count[0]), 0);
    chk("t5_s_ready", 32'(s_ready[0]), 0);
    s_valid = 1'b0;
    repeat (2) cyc();
    reset = 1'b0;
    sc0 = sof_cnt[0];
    pulse_start();
    run_frame(1'b0);
    chk("t5_restart_sof", 32'(sof_cnt[0] - sc0), 1);
    chk("t5_restart_sof_pix", 32'(sof_pix[0]), 32'h10);
    chk("t5_frame_count_after", 32'(frame_count[0]), 1);

    repeat (2) cyc();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
